// File: rtl/cache_pkg.sv
// cache_pkg: geometry constants and FSM state encoding shared by the cache controller files.
// Revision 1.0
`default_nettype none

package cache_pkg;
  localparam int BLOCKS    = 256;
  localparam int WORDS     = 16;
  localparam int SIZE      = 32;
  localparam int TAG_BITS  = 20;
  localparam int IDX_BITS  = 8;
  localparam int OFF_BITS  = 4;
  localparam int ADDR_BITS = TAG_BITS + IDX_BITS + OFF_BITS;
  localparam int LINE_BITS = WORDS * SIZE;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    COMPARE = 3'd2,
    MEM_RD  = 3'd3,
    FILL    = 3'd4,
    MEM_WR  = 3'd5
  } state_t;
endpackage

`default_nettype wire

// File: rtl/cache_controller_if.sv
// cache_controller_if: CPU request bus and memory bus of the cache controller.
// Revision 1.0
`default_nettype none

interface cache_controller_if;
  import cache_pkg::*;

  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [SIZE-1:0]      cpu_wdata;
  logic [SIZE-1:0]      cpu_rdata;
  logic                 cpu_ready;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [SIZE-1:0]      mem_wdata;
  logic                 mem_ack;
  logic [LINE_BITS-1:0] mem_rdata;

  // slave: the controller side (serves the CPU, masters the memory)
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  // master: the CPU/memory environment side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/cache_stats.sv
// cache_stats: saturating hit/miss counters for first-lookup outcomes.
// Revision 1.0
`default_nettype none

module cache_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hit,
  input  logic        i_miss,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
);
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (i_hit && (r_hit_cnt != 32'hFFFF_FFFF))
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (i_miss && (r_miss_cnt != 32'hFFFF_FFFF))
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
endmodule

`default_nettype wire

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-through, no-write-allocate cache control FSM.
// Revision 1.0 -- optional CACHE_STATS_EN adds hit_cnt/miss_cnt outputs.
`default_nettype none

module cache_controller
  import cache_pkg::*;
#(
  parameter int TAG_W  = TAG_BITS,
  parameter int IDX_W  = IDX_BITS,
  parameter int OFF_W  = OFF_BITS,
  parameter int WORD_W = SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  cache_controller_if.slave             bus,
  output logic                          cache_mode,
  output logic [IDX_W-1:0]              cache_index,
  output logic [OFF_W-1:0]              cache_blk_offset,
  output logic [TAG_W-1:0]              cache_tagin,
  output logic [(WORD_W << OFF_W)-1:0]  cache_datain,
  input  logic [WORD_W-1:0]             cache_dataout,
  input  logic [TAG_W-1:0]              cache_tagout,
  input  logic                          cache_valid
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt
`endif
);
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int LINE_W = WORD_W << OFF_W;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_rdata;
  logic                r_ready;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;
  logic                r_mode;
  logic [LINE_W-1:0]   r_line;
  logic                r_wr_hit;
  logic                r_refetch;
  logic                r_first;

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [OFF_W-1:0]    w_off;
  logic                w_hit;

  assign w_tag = r_addr[ADDR_W-1 -: TAG_W];
  assign w_idx = r_addr[OFF_W +: IDX_W];
  assign w_off = r_addr[OFF_W-1:0];
  assign w_hit = cache_valid && (cache_tagout == w_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mode      <= 1'b0;
      r_line      <= '0;
      r_wr_hit    <= 1'b0;
      r_refetch   <= 1'b0;
      r_first     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          // r_ready high means this cycle is the completion pulse of the last request
          if (bus.cpu_req && !r_ready) begin
            r_addr    <= bus.cpu_addr;
            r_we      <= bus.cpu_we;
            r_wdata   <= bus.cpu_wdata;
            r_refetch <= 1'b0;
            r_first   <= 1'b1;
            r_state   <= LOOKUP;
          end
        end
        LOOKUP: r_state <= COMPARE;
        COMPARE: begin
          r_first <= 1'b0;
          if (r_we && r_refetch) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else if (r_we) begin
            r_wr_hit    <= w_hit;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state     <= MEM_WR;
          end else if (w_hit) begin
            r_rdata <= cache_dataout;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_state <= MEM_RD;
          end
        end
        MEM_RD: begin
          // request is raised on entry so a refetch after MEM_WR leaves a one-cycle gap
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
          end else if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_line    <= bus.mem_rdata;
            r_mode    <= 1'b1;
            r_state   <= FILL;
          end
        end
        FILL: begin
          r_mode    <= 1'b0;
          r_refetch <= r_we;
          r_state   <= LOOKUP;
        end
        MEM_WR: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_wr_hit) begin
              r_state <= MEM_RD;
            end else begin
              r_ready <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata  = r_rdata;
  assign bus.cpu_ready  = r_ready;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

  assign cache_mode       = r_mode;
  assign cache_index      = w_idx;
  assign cache_blk_offset = w_off;
  assign cache_tagin      = w_tag;
  assign cache_datain     = r_line;

`ifdef CACHE_STATS_EN
  logic w_hit_evt;
  logic w_miss_evt;

  // only the first COMPARE of a request counts; post-refill lookups are not events
  assign w_hit_evt  = (r_state == COMPARE) && r_first && w_hit;
  assign w_miss_evt = (r_state == COMPARE) && r_first && !w_hit;

  cache_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .i_hit      (w_hit_evt),
    .i_miss     (w_miss_evt),
    .o_hit_cnt  (hit_cnt),
    .o_miss_cnt (miss_cnt)
  );
`endif
endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed vector table, reset corner cases and randomized traffic vs a line-residency model.
// Revision 1.0
`default_nettype none

module tb_cache_controller;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_controller_if bus();

  logic         cache_mode;
  logic [7:0]   cache_index;
  logic [3:0]   cache_blk_offset;
  logic [19:0]  cache_tagin;
  logic [511:0] cache_datain;
  logic [31:0]  cache_dataout;
  logic [19:0]  cache_tagout;
  logic         cache_valid;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  cache_controller dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .cache_mode       (cache_mode),
    .cache_index      (cache_index),
    .cache_blk_offset (cache_blk_offset),
    .cache_tagin      (cache_tagin),
    .cache_datain     (cache_datain),
    .cache_dataout    (cache_dataout),
    .cache_tagout     (cache_tagout),
    .cache_valid      (cache_valid)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cache array: registered read, write while cache_mode is high
  logic         arr_clr;
  logic [511:0] arr_data [256];
  logic [19:0]  arr_tag  [256];
  logic         arr_v    [256];

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int i = 0; i < 256; i++) arr_v[i] <= 1'b0;
    end else if (cache_mode) begin
      arr_data[cache_index] <= cache_datain;
      arr_tag[cache_index]  <= cache_tagin;
      arr_v[cache_index]    <= 1'b1;
    end
    cache_dataout <= arr_data[cache_index][cache_blk_offset*32 +: 32];
    cache_tagout  <= arr_tag[cache_index];
    cache_valid   <= arr_v[cache_index];
  end

  // Backing memory: unwritten words hold a pattern where line 0x0000123 has word k = k
  logic [31:0] mem_m   [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[31:4] ^ 28'h0000123, a[3:0]};
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tx_t;

  tx_t txq[$];
  int  mem_lat  = 1;
  bit  mem_busy = 1'b0;

  // Memory responder: once a request is seen it always acks after mem_lat cycles
  initial begin
    tx_t t;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        mem_busy = 1'b1;
        t.we    = bus.mem_we;
        t.addr  = bus.mem_addr;
        t.wdata = bus.mem_wdata;
        txq.push_back(t);
        repeat (mem_lat) @(negedge clk);
        if (t.we) mem_m[t.addr] = t.wdata;
        else for (int k = 0; k < 16; k++)
          bus.mem_rdata[k*32 +: 32] = mem_get({t.addr[31:4], 4'(k)});
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("mem_req_drop_after_ack", 64'(bus.mem_req), 64'd0);
        mem_busy = 1'b0;
      end
    end
  end

  int          fill_cnt  = 0;
  int          ready_cnt = 0;
  logic [19:0] fill_tag;
  logic [7:0]  fill_idx;

  always @(negedge clk) begin
    if (cache_mode) begin
      fill_cnt++;
      fill_tag = cache_tagin;
      fill_idx = cache_index;
    end
    if (bus.cpu_ready) ready_cnt++;
  end

  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit fresh,
                        output logic [31:0] rd, output int lat, output bit ok);
    if (fresh) begin
      bus.cpu_req = 1'b0;
      @(negedge clk);
    end
    txq.delete();
    fill_cnt  = 0;
    ready_cnt = 0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ready) begin
        ok = 1'b1;
        break;
      end
    end
    rd = bus.cpu_rdata;
    if (!ok) chk("req_timeout", 64'd0, 64'd1);
    if (fresh) bus.cpu_req = 1'b0;
  endtask

  function automatic int count_tx(input bit we);
    int n = 0;
    foreach (txq[j]) if (txq[j].we == we) n++;
    return n;
  endfunction

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          nrd;
    int          nwr;
    int          lat;
    int          fills;
    logic [19:0] ftag;
  } vec_t;

  task automatic run_vec(input int i, input vec_t v);
    logic [31:0] rd;
    int          lat;
    bit          ok;
    do_req(v.we, v.addr, v.wdata, 1'b1, rd, lat, ok);
    @(negedge clk);
    if (!v.we) chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(v.exp_rd));
    chk($sformatf("v%0d_mem_reads", i), 64'(count_tx(1'b0)), 64'(v.nrd));
    chk($sformatf("v%0d_mem_writes", i), 64'(count_tx(1'b1)), 64'(v.nwr));
    if (v.lat > 0) chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d_ready_pulses", i), 64'(ready_cnt), 64'd1);
    chk($sformatf("v%0d_fill_cycles", i), 64'(fill_cnt), 64'(v.fills));
    if (v.fills > 0) begin
      chk($sformatf("v%0d_fill_tag", i), 64'(fill_tag), 64'(v.ftag));
      chk($sformatf("v%0d_fill_idx", i), 64'(fill_idx), 64'(v.addr[11:4]));
    end
    if (v.we && txq.size() > 0) chk($sformatf("v%0d_write_first", i), 64'(txq[0].we), 64'd1);
    foreach (txq[j]) begin
      if (txq[j].we) begin
        chk($sformatf("v%0d_wr_addr", i), 64'(txq[j].addr), 64'(v.addr));
        chk($sformatf("v%0d_wr_data", i), 64'(txq[j].wdata), 64'(v.wdata));
      end else begin
        chk($sformatf("v%0d_rd_addr", i), 64'(txq[j].addr), 64'({v.addr[31:4], 4'h0}));
      end
    end
  endtask

  vec_t vecs[9];
  int   ref_tag[256];

  initial begin
    logic [31:0] rd, a, wd, exp_rd;
    int          lat, exp_nrd, exp_nwr;
    bit          ok, we, fresh, hit;
    logic [19:0] tg;
    logic [7:0]  ix;
    logic [19:0] tag_pool [4];
    logic [7:0]  idx_pool [4];

    vecs[0] = '{1'b0, 32'h0000_1233, 32'h0, dflt(32'h0000_1233), 1, 0, 0, 1, 20'h00001};
    vecs[1] = '{1'b0, 32'h0000_1233, 32'h0, dflt(32'h0000_1233), 0, 0, 3, 0, 20'h0};
    vecs[2] = '{1'b0, 32'hABCD_E235, 32'h0, dflt(32'hABCD_E235), 1, 0, 0, 1, 20'hABCDE};
    vecs[3] = '{1'b0, 32'hABCD_E125, 32'h0, dflt(32'hABCD_E125), 1, 0, 0, 1, 20'hABCDE};
    vecs[4] = '{1'b0, 32'h0000_1233, 32'h0, 32'h0000_0003,       1, 0, 0, 1, 20'h00001};
    vecs[5] = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0,       1, 1, 0, 1, 20'h00001};
    vecs[6] = '{1'b0, 32'h0000_1234, 32'h0, 32'hDEAD_BEEF,       0, 0, 3, 0, 20'h0};
    vecs[7] = '{1'b1, 32'h0000_5678, 32'h1357_2468, 32'h0,       0, 1, 0, 0, 20'h0};
    vecs[8] = '{1'b0, 32'h0000_5678, 32'h0, 32'h1357_2468,       1, 0, 0, 1, 20'h00005};

    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    rst     = 1'b1;
    arr_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 64'(bus.cpu_ready), 64'd0);
    chk("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    chk("rst_mem_req",   64'(bus.mem_req),   64'd0);
    chk("rst_mem_we",    64'(bus.mem_we),    64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_cache_mode", 64'(cache_mode),   64'd0);
    rst     = 1'b0;
    arr_clr = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
`ifdef CACHE_STATS_EN
      if (i == 2) begin
        chk("stats_hit_cnt",  64'(hit_cnt),  64'd1);
        chk("stats_miss_cnt", 64'(miss_cnt), 64'd2);
      end
`endif
    end

    // cpu_req held high through the completion cycle must not start a second request
    do_req(1'b0, 32'h0000_1234, 32'h0, 1'b1, rd, lat, ok);
    bus.cpu_req = 1'b1;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_req_ready_pulses", 64'(ready_cnt), 64'd1);
    chk("hold_req_mem_tx", 64'(txq.size()), 64'd0);

    // reset while MEM_RD waits, with the ack arriving after reset is released
    txq.delete();
    ready_cnt = 0;
    mem_lat   = 8;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_7771;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_mid_memreq_seen", 64'(ok), 64'd1);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    chk("rst_mid_mem_req_async", 64'(bus.mem_req),   64'd0);
    chk("rst_mid_mem_addr",      64'(bus.mem_addr),  64'd0);
    chk("rst_mid_cache_mode",    64'(cache_mode),    64'd0);
    chk("rst_mid_cpu_rdata",     64'(bus.cpu_rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!mem_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_mid_late_ack_done", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_ready", 64'(ready_cnt), 64'd0);
    chk("rst_mid_no_new_req", 64'(txq.size()), 64'd1);
    chk("rst_mid_mem_req_idle", 64'(bus.mem_req), 64'd0);
    mem_lat = 1;
    run_vec(100, '{1'b0, 32'h0000_7771, 32'h0, dflt(32'h0000_7771), 1, 0, 0, 1, 20'h00007});

    // randomized traffic against a line-residency model
    arr_clr = 1'b1;
    @(negedge clk);
    arr_clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_tag[i] = -1;
    ref_mem = mem_m;
    tag_pool[0] = 20'h00000; tag_pool[1] = 20'hABCDE; tag_pool[2] = 20'h12345; tag_pool[3] = 20'h00001;
    idx_pool[0] = 8'h12; idx_pool[1] = 8'h23; idx_pool[2] = 8'h55; idx_pool[3] = 8'h80;
    for (int it = 0; it < 150; it++) begin
      we    = ($urandom_range(0, 2) == 0);
      tg    = tag_pool[$urandom_range(0, 3)];
      ix    = idx_pool[$urandom_range(0, 3)];
      a     = {tg, ix, 4'($urandom_range(0, 15))};
      wd    = $urandom;
      fresh = $urandom_range(0, 1);
      mem_lat = $urandom_range(0, 3);
      hit   = (ref_tag[ix] == int'(tg));
      exp_rd = 32'h0;
      if (!we) begin
        exp_nrd = hit ? 0 : 1;
        exp_nwr = 0;
        ref_tag[ix] = int'(tg);
        exp_rd = ref_get(a);
      end else begin
        exp_nrd = hit ? 1 : 0;
        exp_nwr = 1;
        ref_mem[a] = wd;
      end
      do_req(we, a, wd, fresh, rd, lat, ok);
      if (!we) chk($sformatf("rnd%0d_rdata", it), 64'(rd), 64'(exp_rd));
      chk($sformatf("rnd%0d_mem_reads", it), 64'(count_tx(1'b0)), 64'(exp_nrd));
      chk($sformatf("rnd%0d_mem_writes", it), 64'(count_tx(1'b1)), 64'(exp_nwr));
      foreach (txq[j]) begin
        if (txq[j].we) chk($sformatf("rnd%0d_wr_addr", it), 64'({txq[j].addr, txq[j].wdata}), 64'({a, wd}));
        else chk($sformatf("rnd%0d_rd_addr", it), 64'(txq[j].addr), 64'({a[31:4], 4'h0}));
      end
    end
    bus.cpu_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "time limit");
  end
endmodule

`default_nettype wire
